// File: rtl/hammu_pkg.sv
// Shared definitions for the hammu arithmetic cores (exponent, logarithm):
// handshake FSM state encodings and default operand widths.
package hammu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CALC   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam int LOG_PW = 30;
  localparam int LOG_XW = 4;
  localparam int LOG_AW = 5;

endpackage

// File: rtl/log_mul_cmp.sv
// Combinational acc*X product with a <= compare against P.
// The product keeps its full PW+XW width so the compare never sees a wrapped value.
module log_mul_cmp
  import hammu_pkg::*;
#(
  parameter int PW = LOG_PW,
  parameter int XW = LOG_XW
) (
  input  logic [PW-1:0]    acc,
  input  logic [XW-1:0]    x,
  input  logic [PW-1:0]    p,
  output logic [PW+XW-1:0] prod,
  output logic             le
);

  // Widen both operands before multiplying so no product bits are lost.
  always_comb begin
    prod = {{XW{1'b0}}, acc} * {{PW{1'b0}}, x};
    le   = (prod <= {{XW{1'b0}}, p});
  end

endmodule

// File: rtl/logarithm.sv
// Iterative integer logarithm A = floor(log_X(P)) with exact-power flag.
// Define LOGARITHM_REMAINDER_EN to drive o_R = P - X^A; otherwise o_R is tied to 0.
module logarithm
  import hammu_pkg::*;
#(
  parameter int PW = LOG_PW,
  parameter int XW = LOG_XW,
  parameter int AW = LOG_AW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_start,
  input  logic [XW-1:0] i_X,
  input  logic [PW-1:0] i_P,
  output logic          o_done,
  output logic [AW-1:0] o_A,
  output logic          o_exact,
  output logic          o_err,
  output logic [PW-1:0] o_R
);

  localparam logic [PW-1:0] ACC_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_e              state_r;
  logic [XW-1:0]       reg_x_r;
  logic [PW-1:0]       reg_p_r;
  logic [PW-1:0]       acc_r;
  logic [AW-1:0]       cnt_r;
  logic [PW+XW-1:0]    prod_s;
  logic                le_s;
  logic                err_s;
  logic [PW-1:0]       rem_s;
  logic [PW-1:0]       rem_err_s;

  log_mul_cmp #(.PW(PW), .XW(XW)) u_mul_cmp (
    .acc  (acc_r),
    .x    (reg_x_r),
    .p    (reg_p_r),
    .prod (prod_s),
    .le   (le_s)
  );

  // Operand check and remainder; operands are constant during CALC so checking every cycle equals checking the first.
  always_comb begin
    err_s = (reg_x_r[XW-1:1] == {(XW-1){1'b0}}) || (reg_p_r == {PW{1'b0}});
`ifdef LOGARITHM_REMAINDER_EN
    rem_s     = reg_p_r - acc_r;
    rem_err_s = reg_p_r;
`else
    rem_s     = {PW{1'b0}};
    rem_err_s = {PW{1'b0}};
`endif
  end

  // Handshake FSM, accumulator and registered result outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      reg_x_r <= {XW{1'b0}};
      reg_p_r <= {PW{1'b0}};
      acc_r   <= ACC_ONE;
      cnt_r   <= {AW{1'b0}};
      o_done  <= 1'b0;
      o_A     <= {AW{1'b0}};
      o_exact <= 1'b0;
      o_err   <= 1'b0;
      o_R     <= {PW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          acc_r   <= ACC_ONE;
          cnt_r   <= {AW{1'b0}};
          o_done  <= 1'b0;
          o_A     <= {AW{1'b0}};
          o_exact <= 1'b0;
          o_err   <= 1'b0;
          o_R     <= {PW{1'b0}};
          if (i_load) begin
            reg_x_r <= i_X;
            reg_p_r <= i_P;
            state_r <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (i_start) begin
            state_r <= ST_CALC;
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_CALC: begin
          if (i_start) begin
            state_r <= ST_CALC;
          end else if (err_s) begin
            state_r <= ST_FINISH;
            o_done  <= 1'b1;
            o_A     <= {AW{1'b0}};
            o_exact <= 1'b0;
            o_err   <= 1'b1;
            o_R     <= rem_err_s;
          end else if (le_s) begin
            acc_r <= prod_s[PW-1:0];
            cnt_r <= cnt_r + CNT_ONE;
          end else begin
            state_r <= ST_FINISH;
            o_done  <= 1'b1;
            o_A     <= cnt_r;
            o_exact <= (acc_r == reg_p_r);
            o_err   <= 1'b0;
            o_R     <= rem_s;
          end
        end
        ST_FINISH: begin
          if (i_start) begin
            state_r <= ST_IDLE;
            o_done  <= 1'b0;
            o_A     <= {AW{1'b0}};
            o_exact <= 1'b0;
            o_err   <= 1'b0;
            o_R     <= {PW{1'b0}};
          end else begin
            state_r <= ST_FINISH;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logarithm.sv
// Directed scoreboard bench for the logarithm core.
// Remainder expectations follow LOGARITHM_REMAINDER_EN.
module tb_logarithm;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_load;
  logic        i_start;
  logic [3:0]  i_X;
  logic [29:0] i_P;
  logic        o_done;
  logic [4:0]  o_A;
  logic        o_exact;
  logic        o_err;
  logic [29:0] o_R;

  typedef struct {
    int     a;
    bit     exact;
    bit     err;
    longint r;
    int     lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logarithm dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (i_load),
    .i_start (i_start),
    .i_X     (i_X),
    .i_P     (i_P),
    .o_done  (o_done),
    .o_A     (o_A),
    .o_exact (o_exact),
    .o_err   (o_err),
    .o_R     (o_R)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic longint rexp(input longint v);
`ifdef LOGARITHM_REMAINDER_EN
    return v;
`else
    return 64'sd0;
`endif
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int a, input bit exact, input bit err, input longint r, input int lat);
    exp_t e;
    e.a = a; e.exact = exact; e.err = err; e.r = rexp(r); e.lat = lat;
    sb.push_back(e);
  endtask

  // Load operands and move to CALC; with both=1 load and start are raised together first.
  task automatic start_op(input logic [3:0] x, input logic [29:0] p, input bit both);
    i_X = x; i_P = p; i_load = 1'b1; i_start = both;
    tick();
    i_load = 1'b0;
    if (both) begin
      i_start = 1'b0;
      repeat (4) tick();
      check("load_only", longint'(o_done), 64'sd0);
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Wait (bounded) for done, compare against scoreboard head, then acknowledge.
  task automatic finish_op(input string tag, input int pre);
    int   cyc;
    exp_t e;
    cyc = pre;
    while (!o_done && cyc < 200) begin
      tick();
      cyc++;
    end
    check({tag, "_done"}, longint'(o_done), 64'sd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'sd0, 64'sd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_lat"},   longint'(cyc),     longint'(e.lat));
      check({tag, "_A"},     longint'(o_A),     longint'(e.a));
      check({tag, "_exact"}, longint'(o_exact), longint'(e.exact));
      check({tag, "_err"},   longint'(o_err),   longint'(e.err));
      check({tag, "_R"},     longint'(o_R),     e.r);
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check({tag, "_ack"}, longint'(o_done), 64'sd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_done"},  longint'(o_done),  64'sd0);
    check({tag, "_A"},     longint'(o_A),     64'sd0);
    check({tag, "_exact"}, longint'(o_exact), 64'sd0);
    check({tag, "_err"},   longint'(o_err),   64'sd0);
    check({tag, "_R"},     longint'(o_R),     64'sd0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_load = 1'b0; i_start = 1'b0; i_X = 4'd0; i_P = 30'd0;
    repeat (3) tick();
    i_rst_n = 1'b1;
    check_zero("reset");

    push(10, 1'b1, 1'b0, 64'sd0, 11);
    start_op(4'd2, 30'd1024, 1'b0);
    finish_op("x2_p1024", 0);

    // i_load during CALC must not disturb the captured operands.
    push(4, 1'b0, 1'b0, 64'sd19, 5);
    start_op(4'd3, 30'd100, 1'b0);
    i_load = 1'b1; i_X = 4'd2; i_P = 30'd7;
    repeat (2) tick();
    i_load = 1'b0;
    finish_op("x3_p100", 2);

    push(7, 1'b0, 1'b0, 64'sd902882448, 8);
    start_op(4'd15, 30'd1073741823, 1'b0);
    finish_op("x15_pmax", 0);

    push(29, 1'b0, 1'b0, 64'sd536870911, 30);
    start_op(4'd2, 30'd1073741823, 1'b0);
    finish_op("x2_pmax", 0);

    push(0, 1'b1, 1'b0, 64'sd0, 1);
    start_op(4'd7, 30'd1, 1'b0);
    finish_op("p1", 0);

    push(0, 1'b0, 1'b1, 64'sd50, 1);
    start_op(4'd1, 30'd50, 1'b0);
    finish_op("x1_err", 0);

    push(0, 1'b0, 1'b1, 64'sd0, 1);
    start_op(4'd5, 30'd0, 1'b0);
    finish_op("p0_err", 0);

    // Stall mid-CALC: only cycles with i_start low count.
    push(6, 1'b1, 1'b0, 64'sd0, 7);
    start_op(4'd2, 30'd64, 1'b0);
    repeat (3) tick();
    i_start = 1'b1;
    repeat (5) tick();
    check("stall_done", longint'(o_done), 64'sd0);
    i_start = 1'b0;
    finish_op("stall", 3);

    // Reset while a result is being held must clear it.
    start_op(4'd0, 30'd9, 1'b0);
    repeat (3) tick();
    check("pre_rst_err", longint'(o_err), 64'sd1);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    check_zero("rst_finish");

    // Reset mid-CALC, then a fresh load with load+start together.
    start_op(4'd2, 30'd1024, 1'b0);
    repeat (3) tick();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    check_zero("rst_calc");
    push(2, 1'b0, 1'b0, 64'sd899, 3);
    start_op(4'd10, 30'd999, 1'b1);
    finish_op("x10_p999", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logarithm.md
Name: logarithm

Overview:
- Inverse companion to the exponent core: given result P and base X, computes the integer logarithm A = floor(log_X(P)), the largest A with X^A <= P.
- Also reports whether P is an exact power (X^A == P).
- Uses the same i_load/i_start/o_done handshake as the exponent core, so the same AXI4-Lite register wrapper style can host it.
- Iterative: one multiply-compare per active CALC cycle.

Parameters:
- PW, 30, width of operand P and of the accumulator compare range.
- XW, 4, width of base X.
- AW, 5, width of result A (holds 0..29 for PW=30, X>=2).

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset, synchronous, active-low
- i_load  input  1  capture i_X/i_P when in IDLE
- i_start  input  1  arm/acknowledge strobe (same use as exponent core)
- i_X  input  XW  base
- i_P  input  PW  value whose log is taken
- o_done  output  1  result valid
- o_A  output  AW  integer logarithm
- o_exact  output  1  1 when X^A == P
- o_err  output  1  illegal operands (X<2 or P==0)
- o_R  output  PW  remainder P - X^A (see Optional Feature)

Behaviour:
- Reset: i_clk, synchronous active-low i_rst_n; sampled only on the rising edge of i_clk. All outputs 0, state IDLE, acc=1, cnt=0.
- States (2-bit): IDLE, LOAD, CALC, FINISH.
- IDLE: o_done=0, outputs cleared to 0, acc=1, cnt=0. On i_load=1, capture reg_X=i_X and reg_P=i_P, then go to LOAD.
- LOAD: stay until i_start=1, then go to CALC.
- CALC: advances only on cycles with i_start=0; i_start=1 stalls with all registers held.
  - First active cycle: if reg_X<2 or reg_P==0, set err, go to FINISH with A=0.
  - Each active cycle: prod = acc*reg_X, width PW+XW, no truncation.
    - If prod <= reg_P: acc<=prod, cnt<=cnt+1.
    - Else: go to FINISH.
  - Latency: A+1 active cycles (+1 for the error check when folded into the first cycle; the implementation folds it in, so the error path takes 1 cycle).
- FINISH:
  - o_done=1, o_A=cnt, o_exact=(acc==reg_P)&~err, o_err=err, o_R per feature.
  - Outputs hold while in FINISH.
  - i_start=1 returns to IDLE, clearing o_done next cycle.
- Boundaries:
  - P=1 with X>=2 gives A=0, exact=1.
  - acc never exceeds reg_P, so no overflow.
  - cnt cannot exceed 29 for PW=30.
  - i_load outside IDLE is ignored.
  - Reset asserted in any state returns to IDLE on the next edge and discards the operation.
  - i_load and i_start both high in IDLE: load only; start must be seen in LOAD.

Optional Feature:
- Macro LOGARITHM_REMAINDER_EN.
- Defined: FINISH drives o_R = reg_P - acc, one subtractor; on error o_R = reg_P.
- Undefined: subtractor omitted, o_R tied to 0. Port list is unchanged so wrappers are identical.

Decomposition:
- Shared package `hammu_pkg`:
  - state encodings: IDLE/LOAD/CALC/FINISH, shared with the exponent core.
  - width constants PW/XW/AW.
- Sub-module `log_mul_cmp`: combinational acc*X product plus <= compare against P. Reusable by a future root extractor.

Test Plan:
- X=2, P=1024, load, start pulse, start low → A=10, exact=1, err=0, R=0; o_done after 11 active CALC cycles.
- X=3, P=100 → A=4, exact=0, R=19 (with macro), R=0 (without).
- X=15, P=1073741823 → A=7, exact=0, R=902882448; X=2, same P → A=29, R=536870911.
- X=1, P=50, then X=5, P=0 → err=1, A=0, exact=0, done after 1 active cycle.
- Hold i_start=1 for 5 cycles mid-CALC (X=2, P=64) → cnt frozen during stall, final A=6, exact=1.
- Assert i_rst_n=0 for one cycle mid-CALC → next cycle IDLE, all outputs 0; new load X=10, P=999 → A=2, R=899.
